// File: rtl/mpu_pkg.sv
// Shared definitions for the MPU flattened-matrix bus.
//   N, W, MAT_W : matrix dimension, element width, flattened matrix width
//   elem_off    : bit offset of element (r,c) inside a flattened matrix
//   state_t     : streamer control states
package mpu_pkg;

    localparam int unsigned N     = 5;
    localparam int unsigned W     = 8;
    localparam int unsigned MAT_W = N * N * W;

    typedef enum logic {
        IDLE,
        STREAM
    } state_t;

    // Element layout of a flattened matrix. Every reader and writer of the
    // bus uses this, so the layout lives in exactly one place.
    function automatic int unsigned elem_off(input int unsigned r, input int unsigned c);
        return W * (r + N * c);
    endfunction

endpackage

// File: rtl/mpu_rc_counter.sv
// Row/column index counter for walking an N x N matrix in row-major order.
// The column index increments fastest; wrapping from (N-1,N-1) returns to (0,0).
//   clk      : system clock
//   reset    : synchronous active-high reset, indices to (0,0)
//   clear    : synchronous restart at (0,0)
//   enable   : advance one element
//   row, col : current indices
//   next_row, next_col : indices the counter moves to on the next enable
//   last     : current position is (N-1,N-1)
module mpu_rc_counter #(
    parameter int unsigned N  = 5,
    localparam int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clear,
    input  logic          enable,
    output logic [IW-1:0] row,
    output logic [IW-1:0] col,
    output logic [IW-1:0] next_row,
    output logic [IW-1:0] next_col,
    output logic          last
);

    localparam logic [IW-1:0] MAX_IDX = IW'(N - 1);

    always_comb begin
        next_row = row;
        next_col = col;
        if (col == MAX_IDX) begin
            next_col = '0;
            if (row == MAX_IDX) begin
                next_row = '0;
            end else begin
                next_row = row + 1'b1;
            end
        end else begin
            next_col = col + 1'b1;
        end
    end

    assign last = (row == MAX_IDX) && (col == MAX_IDX);

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            row <= '0;
            col <= '0;
        end else if (enable) begin
            row <= next_row;
            col <= next_col;
        end
    end

endmodule

// File: rtl/mpu_matrix_streamer.sv
// Reader side of the MPU flattened-matrix bus. Captures one N x N matrix in a
// single load handshake, then streams its elements row-major, one per beat,
// with row/column tags and a last flag.
//   clk, reset   : system clock, synchronous active-high reset
//   load_valid   : source presents a matrix on load_matrix
//   load_ready   : streamer idle and able to accept a matrix
//   load_matrix  : flattened matrix, element (r,c) at elem_off(r,c)
//   out_valid    : out_data/out_row/out_col/out_last carry a beat
//   out_ready    : sink accepts the current beat
//   out_data     : element value
//   out_row/col  : element indices
//   out_last     : beat is element (N-1,N-1)
//   busy         : a matrix is being streamed
module mpu_matrix_streamer #(
    parameter int unsigned N     = mpu_pkg::N,
    parameter int unsigned W     = mpu_pkg::W,
    parameter int unsigned MAT_W = N * N * W,
    localparam int unsigned IW   = (N > 1) ? $clog2(N) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [MAT_W-1:0] load_matrix,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W-1:0]     out_data,
    output logic [IW-1:0]    out_row,
    output logic [IW-1:0]    out_col,
    output logic             out_last,
    output logic             busy
);

    import mpu_pkg::*;

    state_t           state;
    state_t           state_next;
    logic [MAT_W-1:0] mat_q;
    logic             load_fire;
    logic             xfer;
    logic             at_last;
    logic [IW-1:0]    next_row;
    logic [IW-1:0]    next_col;

    mpu_rc_counter #(
        .N (N)
    ) u_rc (
        .clk      (clk),
        .reset    (reset),
        .clear    (load_fire),
        .enable   (xfer),
        .row      (out_row),
        .col      (out_col),
        .next_row (next_row),
        .next_col (next_col),
        .last     (at_last)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        load_ready = 1'b0;
        out_valid  = 1'b0;
        busy       = 1'b0;
        load_fire  = 1'b0;
        xfer       = 1'b0;
        unique case (state)
            IDLE: begin
                load_ready = 1'b1;
                load_fire  = load_valid;
                if (load_valid) begin
                    state_next = STREAM;
                end
            end
            STREAM: begin
                out_valid = 1'b1;
                busy      = 1'b1;
                xfer      = out_ready;
                if (out_ready && at_last) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // The counter and the state register already reflect the last beat only
    // while streaming; gating keeps out_last low in IDLE after the wrap.
    assign out_last = out_valid && at_last;

    // out_data is registered one element ahead: on each transfer it is loaded
    // with the element the counter is about to point at, so no path exists
    // from out_ready into out_data within a cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            mat_q    <= '0;
            out_data <= '0;
        end else if (load_fire) begin
            mat_q    <= load_matrix;
            out_data <= load_matrix[elem_off(0, 0) +: W];
        end else if (xfer) begin
            if (at_last) begin
                out_data <= '0;
            end else begin
                out_data <= mat_q[elem_off(32'(next_row), 32'(next_col)) +: W];
            end
        end
    end

endmodule

// File: tb/tb_mpu_matrix_streamer.sv
// Self-checking bench for mpu_matrix_streamer: directed scenarios plus
// randomized matrices and backpressure, checked against a row-major
// expectation queue built from an N x N element array.
module tb_mpu_matrix_streamer;

    localparam int N     = 5;
    localparam int W     = 8;
    localparam int MAT_W = N * N * W;
    localparam int IW    = 3;

    logic             clk = 1'b0;
    logic             reset;
    logic             load_valid;
    logic             load_ready;
    logic [MAT_W-1:0] load_matrix;
    logic             out_valid;
    logic             out_ready;
    logic [W-1:0]     out_data;
    logic [IW-1:0]    out_row;
    logic [IW-1:0]    out_col;
    logic             out_last;
    logic             busy;

    always #5 clk = ~clk;

    mpu_matrix_streamer dut (
        .clk         (clk),
        .reset       (reset),
        .load_valid  (load_valid),
        .load_ready  (load_ready),
        .load_matrix (load_matrix),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_row     (out_row),
        .out_col     (out_col),
        .out_last    (out_last),
        .busy        (busy)
    );

    int tests = 0;
    int fails = 0;

    logic [W-1:0] mat_m [N][N];

    typedef struct {
        logic [W-1:0] d;
        int           r;
        int           c;
    } beat_t;

    beat_t exp_q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic logic [MAT_W-1:0] pack_m();
        logic [MAT_W-1:0] f;
        f = '0;
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++)
                f[W*(r+N*c) +: W] = mat_m[r][c];
        return f;
    endfunction

    function automatic logic [MAT_W-1:0] rand_flat();
        logic [MAT_W-1:0] f;
        for (int i = 0; i < N*N; i++)
            f[i*W +: W] = W'($urandom);
        return f;
    endfunction

    task automatic fill_index();
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++)
                mat_m[r][c] = W'(r + N*c + 1);
    endtask

    task automatic fill_const(input logic [W-1:0] v);
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++)
                mat_m[r][c] = v;
    endtask

    task automatic fill_rand();
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++)
                mat_m[r][c] = W'($urandom);
    endtask

    // bp_mode: 0 always ready, 1 pattern 1,0,0 repeating, 2 random.
    // abort_after > 0: pulse reset once that many beats have transferred.
    // scramble: drive fresh random load_matrix every cycle after capture.
    // poke: pulse load_valid with an all-zero matrix mid-stream.
    task automatic do_stream(input int bp_mode, input int abort_after,
                             input bit scramble, input bit poke);
        beat_t h;
        bit    rdy;
        int    k;
        int    beats;

        exp_q.delete();
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++) begin
                h.d = mat_m[r][c];
                h.r = r;
                h.c = c;
                exp_q.push_back(h);
            end

        chk("idle_load_ready", load_ready, 1);
        chk("idle_out_valid", out_valid, 0);
        load_valid  = 1'b1;
        load_matrix = pack_m();
        @(posedge clk);
        @(negedge clk);
        load_valid = 1'b0;

        k     = 0;
        beats = 0;
        while (exp_q.size() > 0 && k < 400) begin
            if (scramble) load_matrix = rand_flat();
            if (poke && k == 4) begin
                load_valid  = 1'b1;
                load_matrix = '0;
                chk("busy_load_ready", load_ready, 0);
            end else begin
                load_valid = 1'b0;
            end

            if (abort_after > 0 && beats == abort_after) begin
                load_valid = 1'b0;
                out_ready  = 1'b0;
                reset      = 1'b1;
                @(posedge clk);
                @(negedge clk);
                reset = 1'b0;
                chk("abort_out_valid", out_valid, 0);
                chk("abort_out_row", out_row, 0);
                chk("abort_out_col", out_col, 0);
                chk("abort_out_last", out_last, 0);
                chk("abort_load_ready", load_ready, 1);
                chk("abort_busy", busy, 0);
                exp_q.delete();
                return;
            end

            h = exp_q[0];
            chk("beat_valid", out_valid, 1);
            chk("beat_busy", busy, 1);
            chk("beat_data", out_data, h.d);
            chk("beat_row", out_row, h.r);
            chk("beat_col", out_col, h.c);
            chk("beat_last", out_last, (h.r == N-1 && h.c == N-1) ? 1 : 0);

            case (bp_mode)
                0:       rdy = 1'b1;
                1:       rdy = (k % 3 == 0);
                default: rdy = 1'($urandom_range(0, 1));
            endcase
            out_ready = rdy;
            @(posedge clk);
            @(negedge clk);
            if (rdy) begin
                void'(exp_q.pop_front());
                beats++;
            end
            k++;
        end

        load_valid = 1'b0;
        out_ready  = 1'b0;
        chk("stream_timeout", exp_q.size(), 0);
        chk("end_out_valid", out_valid, 0);
        chk("end_load_ready", load_ready, 1);
        chk("end_busy", busy, 0);
        chk("end_out_last", out_last, 0);
    endtask

    initial begin
        reset       = 1'b1;
        load_valid  = 1'b0;
        out_ready   = 1'b0;
        load_matrix = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;

        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_row", out_row, 0);
        chk("rst_out_col", out_col, 0);
        chk("rst_out_last", out_last, 0);
        chk("rst_busy", busy, 0);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            @(negedge clk);
            chk("idle_load_ready", load_ready, 1);
            chk("idle_out_valid", out_valid, 0);
            chk("idle_busy", busy, 0);
        end

        // Ordering with free-flowing sink
        fill_index();
        do_stream(0, 0, 1'b0, 1'b0);

        // Backpressure pattern 1,0,0,...
        do_stream(1, 0, 1'b0, 1'b0);

        // Reset after beat 7, then an all-0xFF matrix
        do_stream(0, 7, 1'b0, 1'b0);
        @(posedge clk);
        @(negedge clk);
        fill_const(8'hFF);
        do_stream(0, 0, 1'b0, 1'b0);

        // Load attempt while busy is ignored; next load of zeros is accepted
        fill_index();
        do_stream(0, 0, 1'b0, 1'b1);
        fill_const(8'h00);
        do_stream(0, 0, 1'b0, 1'b0);

        // Capture isolation with random backpressure
        fill_rand();
        do_stream(2, 0, 1'b1, 1'b0);

        // load_valid together with reset is ignored
        reset       = 1'b1;
        load_valid  = 1'b1;
        load_matrix = rand_flat();
        @(posedge clk);
        @(negedge clk);
        reset      = 1'b0;
        load_valid = 1'b0;
        chk("rstload_out_valid", out_valid, 0);
        chk("rstload_busy", busy, 0);
        @(posedge clk);
        @(negedge clk);
        chk("rstload_out_valid2", out_valid, 0);
        chk("rstload_load_ready", load_ready, 1);

        // Random matrices, random backpressure, random load_matrix churn
        for (int t = 0; t < 4; t++) begin
            fill_rand();
            do_stream(2, 0, 1'($urandom_range(0, 1)), 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mpu_matrix_streamer.md
Name: mpu_matrix_streamer

Overview:
Reader side of the MPU flattened-matrix bus. It captures one N×N flattened result matrix, such as the output of the MPU add/sub units, in a single handshake. It then streams the elements out one per beat over a valid/ready byte stream, row-major, with row/col tags and a last flag. It sits between the MPU arithmetic units and the host-facing output path.

Parameters:
N, 5, matrix dimension (N×N elements)
W, 8, element width in bits
MAT_W, N*N*W, flattened matrix width (derived; do not override)

Ports:
clk  input  1  system clock; all state updates on rising edge
reset  input  1  synchronous, active-high reset
load_valid  input  1  source presents a matrix on load_matrix
load_ready  output  1  streamer can accept a matrix (high only in IDLE)
load_matrix  input  MAT_W  flattened matrix; element (r,c) at bits [W*(r+N*c) +: W]
out_valid  output  1  out_data/out_row/out_col/out_last valid
out_ready  input  1  sink accepts current beat
out_data  output  W  current element value
out_row  output  clog2(N)  row index of current element
out_col  output  clog2(N)  column index of current element
out_last  output  1  current beat is element (N-1,N-1)
busy  output  1  high in STREAM

Behaviour:
- Reset (synchronous, active-high, dominant over all other inputs): state=IDLE; out_valid=0, out_data=0, out_row=0, out_col=0, out_last=0, busy=0; internal matrix register cleared. load_ready=1 from the first cycle after reset deasserts.
- States: IDLE, STREAM.
- IDLE:
  - load_ready=1, out_valid=0.
  - load_valid=1 at an edge → capture load_matrix into the internal register, row=0, col=0, go to STREAM.
- Capture latency: first beat (0,0) is valid on the cycle after the load handshake.
- STREAM:
  - load_ready=0; load_valid is ignored.
  - out_valid=1, busy=1.
  - out_data = reg[W*(row+N*col) +: W].
  - out_last = (row==N-1 && col==N-1).
- Order: row-major; col increments fastest. col wraps N-1→0 with row+1.
- Beat transfer occurs when out_valid && out_ready at an edge; the counters then advance.
- out_ready=0 → all out_* hold stable, indefinitely. out_valid is never dropped without a transfer.
- Transfer of the last beat → state=IDLE, out_valid=0 next cycle, load_ready=1 next cycle.
  - One-cycle bubble between matrices; back-to-back overlap is not supported.
- Throughput: N*N beats per matrix at out_ready=1, plus one load cycle.
- Outputs are registered; no combinational path from out_ready to out_valid/out_data.
- Data is captured verbatim; the streamer performs no arithmetic and no width change.
- Reset mid-stream: the stream aborts immediately. No out_last is emitted, and the remaining elements are discarded.
- load_valid asserted together with reset: ignored.
- load_matrix changing after capture: no effect on the stream in progress.

Decomposition:
- Shared package mpu_pkg holds:
  - N, W, MAT_W constants
  - function elem_off(r,c) = W*(r+N*c), the single definition of the element layout, shared with the MPU arithmetic units and benches
  - state enum {IDLE, STREAM}
- One sub-module is natural: mpu_rc_counter.
  - It provides row/col counters with enable, clear and wrap, and a last output.
  - It is reusable by a future matrix loader (writer direction).

Test Plan:
- Reset then idle: load_valid=0 → load_ready=1, out_valid=0, busy=0 for 10 cycles.
- Ordering: load matrix whose element at flat index e holds e+1, with out_ready=1.
  - Required: 25 consecutive beats 1,6,11,16,21,2,7,…,25, with out_row/out_col stepping (0,0),(0,1)…(4,4).
  - out_last=1 only on value 25.
  - load_ready returns to 1 the cycle after.
- Backpressure: same matrix, out_ready toggling 1,0,0,1,…
  - Required: out_data/out_row/out_col held constant while out_ready=0.
  - No element is lost or duplicated, and all 25 values arrive in order.
- Reset mid-stream: assert reset after beat 7.
  - Required: next cycle out_valid=0, out_row=out_col=0, load_ready=1.
  - A subsequent load of an all-0xFF matrix streams 25×0xFF.
- Load ignored while busy: pulse load_valid with an all-0x00 matrix during STREAM.
  - Required: the stream continues with the original values.
  - Required: the first load after out_last is accepted and streams 0x00.
- Capture isolation: change load_matrix every cycle after the handshake.
  - Required: the output equals the captured snapshot.
